// File: rtl/cfg_bus_pkg.sv
// Shared encodings, requester indices and helpers
// for the camera/HDMI config-bus arbiter.
package cfg_bus_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } arb_state_t;

   localparam logic [1:0] CAM1 = 2'd0;
   localparam logic [1:0] CAM2 = 2'd1;
   localparam logic [1:0] HDMI = 2'd2;

   // 100 ms at 25.2 MHz
   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd2520000;

   function automatic logic [2:0] onehot3(input logic [1:0] i);
      return 3'b001 << i;
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == HDMI) ? CAM1 : i + 2'd1;
   endfunction

   function automatic logic [7:0] pick_byte(
      input logic [23:0] v,
      input logic [1:0]  i
   );
      logic [7:0] b;
      unique case (i)
         CAM2:    b = v[15:8];
         HDMI:    b = v[23:16];
         default: b = v[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker; the search
// starts at ptr and wraps modulo 3.
module rr_pick3
   import cfg_bus_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = CAM1;
      unique case (ptr)
         CAM2:
            idx = req[1] ? CAM2 :
                  req[2] ? HDMI : CAM1;
         HDMI:
            idx = req[2] ? HDMI :
                  req[0] ? CAM1 : CAM2;
         default:
            idx = req[0] ? CAM1 :
                  req[1] ? CAM2 : HDMI;
      endcase
   end

endmodule

// File: rtl/cfg_bus_arb.sv
// Arbitrates three init sequencers onto one shared
// register-write master, with a WAIT-state watchdog.
module cfg_bus_arb
   import cfg_bus_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int          NUM_REQ        = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_chip_addr,
   input  logic [8*NUM_REQ-1:0]   req_reg_addr,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     err,
   output logic                   m_start,
   output logic [7:0]             m_chip_addr,
   output logic [7:0]             m_reg_addr,
   output logic [7:0]             m_wdata,
   input  logic                   m_done,
   input  logic                   m_nack,
   output logic                   timeout
);

   (* syn_encoding = "safe" *)
   arb_state_t          r_state;
   logic [1:0]          r_ptr;
   logic [1:0]          r_idx;
   logic [23:0]         r_wdog;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  r_ack;
   logic [NUM_REQ-1:0]  r_err;
   logic                r_start;
   logic [7:0]          r_chip;
   logic [7:0]          r_reg;
   logic [7:0]          r_wd;
   logic                r_timeout;

   logic                w_valid;
   logic [1:0]          w_idx;
   logic                w_expire;

   rr_pick3 u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_valid),
      .idx   (w_idx)
   );

   assign w_expire = (r_wdog == TIMEOUT_CYCLES - 24'd1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= CAM1;
         r_idx     <= CAM1;
         r_wdog    <= '0;
         r_gnt     <= '0;
         r_ack     <= '0;
         r_err     <= '0;
         r_start   <= 1'b0;
         r_chip    <= 8'h00;
         r_reg     <= 8'h00;
         r_wd      <= 8'h00;
         r_timeout <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_ack   <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_state <= S_ISSUE;
                  r_idx   <= w_idx;
                  r_gnt   <= onehot3(w_idx);
                  r_start <= 1'b1;
                  r_wdog  <= '0;
                  r_chip  <= pick_byte(req_chip_addr, w_idx);
                  r_reg   <= pick_byte(req_reg_addr, w_idx);
                  r_wd    <= pick_byte(req_wdata, w_idx);
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               r_wdog <= r_wdog + 24'd1;
               // completion beats the watchdog on the same cycle
               if (m_done) begin
                  r_state <= S_RESP;
                  r_ack   <= onehot3(r_idx);
                  r_err   <= m_nack ? onehot3(r_idx) : '0;
               end else if (w_expire) begin
                  r_state   <= S_RESP;
                  r_ack     <= onehot3(r_idx);
                  r_err     <= onehot3(r_idx);
                  r_timeout <= 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_err   <= '0;
               r_ptr   <= next_idx(r_idx);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign ack         = r_ack;
   assign err         = r_err;
   assign m_start     = r_start;
   assign m_chip_addr = r_chip;
   assign m_reg_addr  = r_reg;
   assign m_wdata     = r_wd;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Directed bench for cfg_bus_arb: vector table plus
// hand sequences for sticky timeout and mid-WAIT reset.
module tb_cfg_bus_arb;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [23:0] req_chip_addr;
   logic [23:0] req_reg_addr;
   logic [23:0] req_wdata;
   logic [2:0]  gnt;
   logic [2:0]  ack;
   logic [2:0]  err;
   logic        m_start;
   logic [7:0]  m_chip_addr;
   logic [7:0]  m_reg_addr;
   logic [7:0]  m_wdata;
   logic        m_done;
   logic        m_nack;
   logic        timeout;

   int n_chk = 0;
   int n_err = 0;

   cfg_bus_arb #(
      .TIMEOUT_CYCLES (24'(TO)),
      .NUM_REQ        (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_chip_addr (req_chip_addr),
      .req_reg_addr  (req_reg_addr),
      .req_wdata     (req_wdata),
      .gnt           (gnt),
      .ack           (ack),
      .err           (err),
      .m_start       (m_start),
      .m_chip_addr   (m_chip_addr),
      .m_reg_addr    (m_reg_addr),
      .m_wdata       (m_wdata),
      .m_done        (m_done),
      .m_nack        (m_nack),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [23:0] chip;
      logic [23:0] rega;
      logic [23:0] wd;
      int          done_at;
      logic        nack;
      logic        drop;
      logic [2:0]  after;
      logic [1:0]  idx;
      logic        err;
      logic        to;
   } vec_t;

   vec_t vt[13];

   function automatic vec_t mk(
      input logic [2:0]  r,
      input logic [23:0] c,
      input logic [23:0] ra,
      input logic [23:0] w,
      input int          d,
      input logic        nk,
      input logic        dr,
      input logic [2:0]  af,
      input logic [1:0]  ix,
      input logic        e,
      input logic        t
   );
      vec_t v;
      v.req = r; v.chip = c; v.rega = ra; v.wd = w;
      v.done_at = d; v.nack = nk; v.drop = dr;
      v.after = af; v.idx = ix; v.err = e; v.to = t;
      return v;
   endfunction

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      logic [2:0] oh;
      logic [7:0] ec, er, ew;
      logic       bad;
      int         n;
      int         last;
      oh = 3'b001 << v.idx;
      ec = v.chip[8*v.idx +: 8];
      er = v.rega[8*v.idx +: 8];
      ew = v.wd[8*v.idx +: 8];
      step();
      req           = v.req;
      req_chip_addr = v.chip;
      req_reg_addr  = v.rega;
      req_wdata     = v.wd;
      chk($sformatf("v%0d idle_gnt", k), gnt, 0);
      chk($sformatf("v%0d idle_ack", k), ack, 0);
      step();
      chk($sformatf("v%0d gnt", k), gnt, oh);
      chk($sformatf("v%0d start", k), m_start, 1);
      chk($sformatf("v%0d chip", k), m_chip_addr, ec);
      chk($sformatf("v%0d reg", k), m_reg_addr, er);
      chk($sformatf("v%0d wdata", k), m_wdata, ew);
      if (v.drop) req = v.req & ~oh;
      step();
      n = 2;
      chk($sformatf("v%0d start_pulse", k), m_start, 0);
      last = (v.done_at == 0) ? 2 + TO - 1 : v.done_at;
      bad = 1'b0;
      while (n < last) begin
         if (ack != 3'b000 || gnt != oh) bad = 1'b1;
         step();
         n++;
      end
      if (ack != 3'b000 || m_start) bad = 1'b1;
      if (v.done_at != 0) begin
         m_done = 1'b1;
         m_nack = v.nack;
      end
      step();
      m_done = 1'b0;
      m_nack = 1'b0;
      chk($sformatf("v%0d wait_quiet", k), bad, 0);
      chk($sformatf("v%0d ack", k), ack, oh);
      chk($sformatf("v%0d err", k), err, v.err ? oh : 3'b000);
      chk($sformatf("v%0d timeout", k), timeout, v.to);
      chk($sformatf("v%0d gnt_resp", k), gnt, oh);
      chk($sformatf("v%0d chip_hold", k), m_chip_addr, ec);
      chk($sformatf("v%0d wd_hold", k), m_wdata, ew);
      req = v.after;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b0;
      req = 3'b000;
      req_chip_addr = '0;
      req_reg_addr = '0;
      req_wdata = '0;
      m_done = 1'b0;
      m_nack = 1'b0;
      repeat (2) step();
      chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_start", m_start, 0);
      chk("rst_ops", {m_chip_addr, m_reg_addr, m_wdata}, 0);
      chk("rst_to", timeout, 0);
      reset = 1'b1;

      for (int i = 0; i < 6; i++)
         vt[i] = mk(3'b111, 24'hA2A1A0, 24'hB2B1B0,
                    24'hC2C1C0, 4, 0, 0,
                    (i == 5) ? 3'b000 : 3'b111,
                    2'(i % 3), 0, 0);
      vt[6]  = mk(3'b001, 24'h0000CD, 24'h000012,
                  24'h000080, 10, 0, 0, 3'b000, 2'd0, 0, 0);
      vt[7]  = mk(3'b100, 24'h720000, 24'h410000,
                  24'h100000, 6, 1, 0, 3'b000, 2'd2, 1, 0);
      vt[8]  = mk(3'b010, 24'h003300, 24'h004400,
                  24'h005500, 17, 0, 0, 3'b000, 2'd1, 0, 0);
      vt[9]  = mk(3'b001, 24'h000011, 24'h000022,
                  24'h000033, 5, 0, 1, 3'b000, 2'd0, 0, 0);
      vt[10] = mk(3'b011, 24'h00E1E0, 24'h00F1F0,
                  24'h009190, 3, 0, 0, 3'b000, 2'd1, 0, 0);
      vt[11] = mk(3'b101, 24'h5A005B, 24'h6A006B,
                  24'h7A007B, 3, 0, 0, 3'b000, 2'd2, 0, 0);
      vt[12] = mk(3'b010, 24'h00AB00, 24'h00CD00,
                  24'h00EF00, 0, 0, 0, 3'b000, 2'd1, 1, 1);

      for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

      // late completion while idle must be ignored
      step();
      m_done = 1'b1;
      m_nack = 1'b1;
      step();
      m_done = 1'b0;
      m_nack = 1'b0;
      chk("idle_done_ack", ack, 0);
      chk("idle_done_gnt", gnt, 0);
      repeat (3) step();
      chk("ignored_done_ack", ack, 0);
      chk("to_sticky", timeout, 1);

      // reset in WAIT: ptr is 2 here, so 110 picks 2
      req = 3'b110;
      req_chip_addr = 24'h998877;
      req_reg_addr  = 24'h665544;
      req_wdata     = 24'h332211;
      step();
      chk("pre_rst_gnt", gnt, 3'b100);
      step();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_start", m_start, 0);
      chk("mid_rst_ops", {m_chip_addr, m_reg_addr, m_wdata}, 0);
      chk("mid_rst_to", timeout, 0);
      step();
      chk("post_rst_gnt", gnt, 3'b010);
      chk("post_rst_start", m_start, 1);
      chk("post_rst_chip", m_chip_addr, 8'h88);
      m_done = 1'b1;
      m_nack = 1'b1;
      step();
      m_done = 1'b0;
      m_nack = 1'b0;
      chk("issue_done_ignored", ack, 0);
      m_done = 1'b1;
      step();
      m_done = 1'b0;
      chk("post_rst_ack", ack, 3'b010);
      chk("post_rst_err", err, 0);
      req = 3'b000;
      step();
      chk("post_rst_clear", {gnt, ack}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cfg_bus_arb.md
CFG_BUS_ARB -- requirements
Module: cfg_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd2520000, meaning the WAIT watchdog limit (100 ms at 25.2 MHz).
REQ-002 SHALL have parameter NUM_REQ, default 3, meaning requester count (0 = cam1 init, 1 = cam2 init, 2 = hdmi init); the design need only support 3.
REQ-003 SHALL have port clk, input, width 1, meaning system clock (25.2 MHz).
REQ-004 SHALL have port reset, input, width 1, meaning reset, synchronous, active-low; clock clk.
REQ-005 SHALL have port req, input, width 3, meaning per-requester transaction request, held until ack.
REQ-006 SHALL have port req_chip_addr, input, width 24, meaning packed 8-bit chip address per requester, with requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_reg_addr, input, width 24, meaning packed 8-bit register address per requester.
REQ-008 SHALL have port req_wdata, input, width 24, meaning packed 8-bit write data per requester.
REQ-009 SHALL have port gnt, output, width 3, meaning one-hot grant.
REQ-010 SHALL have port ack, output, width 3, meaning one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port err, output, width 3, meaning error qualifier that is valid only with ack.
REQ-012 SHALL have port m_start, output, width 1, meaning one-cycle start pulse to the shared register-write master.
REQ-013 SHALL have ports m_chip_addr, m_reg_addr and m_wdata, each output, width 8, meaning latched operands to the master.
REQ-014 SHALL have ports m_done and m_nack, each input, width 1, meaning the master's completion pulse and its NACK flag (m_nack valid with m_done).
REQ-015 SHALL have port timeout, output, width 1, meaning a sticky flag set when a transaction was aborted by the watchdog.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE SHALL transition to ISSUE when any req bit is high, and otherwise remain in IDLE.
REQ-018 Selection SHALL be round-robin: the search starts at index ptr and proceeds ptr, ptr+1, ptr+2 mod 3; the first requester with req high wins.
REQ-019 On the IDLE->ISSUE edge, the block SHALL register gnt[winner] and latch the winner's three operand bytes into m_*.
REQ-020 In ISSUE, m_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-021 In WAIT, the watchdog counter SHALL increment every cycle; m_done SHALL transition to RESP with err[i] = m_nack.
REQ-022 In WAIT, a counter value equal to TIMEOUT_CYCLES-1 without m_done SHALL transition to RESP with err[i] = 1 and SHALL set timeout.
REQ-023 When m_done and watchdog expiry coincide, m_done SHALL win: err[i] = m_nack and timeout is not set.
REQ-024 In RESP, ack[i] SHALL be 1 for one cycle; gnt SHALL clear on the next cycle, ptr SHALL become (i+1) mod 3, and the next state SHALL be IDLE.
REQ-025 Latency from req sampled in IDLE (cycle 0) SHALL be: gnt at cycle 1; m_start at cycle 1; state WAIT at cycle 2; ack at cycle N+1 when m_done arrives at cycle N.
REQ-026 m_done and m_nack received outside WAIT SHALL be ignored.
REQ-027 Deasserting req during ISSUE or WAIT SHALL NOT abort the transaction, and ack SHALL still be issued.
REQ-028 A req still high in IDLE after ack SHALL be treated as a new transaction, arbitrated against the other requesters using the updated ptr.
REQ-029 m_* operands SHALL remain stable from ISSUE through RESP.
REQ-030 The watchdog counter SHALL be 24 bits and SHALL clear on every entry to ISSUE.
REQ-031 timeout SHALL be sticky until reset.

Reset
REQ-032 While reset = 0 at a clk edge, the block SHALL set state = IDLE, ptr = 0, gnt = 0, ack = 0, err = 0, m_start = 0, m_chip_addr = m_reg_addr = m_wdata = 8'h00, watchdog = 0 and timeout = 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no ack; the master is reset by the same signal.

Structure
REQ-034 The state encodings, requester index constants (CAM1 = 0, CAM2 = 1, HDMI = 2) and default TIMEOUT_CYCLES SHALL reside in the shared package cfg_bus_pkg.
REQ-035 The round-robin selection SHALL be a separate sub-module rr_pick3 with ports req[2:0], ptr[1:0], outputs valid and idx[1:0], purely combinational.
REQ-036 The state register SHALL carry the safe-encoding synthesis attribute.

Verification
REQ-037 Single request: req = 3'b001, ops CD/12/80; m_done at cycle 10 with m_nack = 0 -> gnt = 001 at cycle 1, m_start one pulse, m_* = CD/12/80, ack[0] at cycle 11 with err[0] = 0.
REQ-038 Fairness: req = 3'b111 held, each transaction acknowledged after 5 cycles -> grant order 0, 1, 2, 0, 1, 2 with no requester granted twice in a row.
REQ-039 NACK: requester 2 with ops 72/41/10 and m_nack = 1 with m_done -> ack[2] = 1, err[2] = 1, timeout = 0.
REQ-040 Timeout: TIMEOUT_CYCLES = 16, m_done never arrives -> ack[i] = 1 and err[i] = 1 at cycle 2+16, timeout = 1 and held.
REQ-041 Coincidence: m_done on the expiry cycle with m_nack = 0 -> err = 0 and timeout = 0.
REQ-042 Reset during WAIT: reset = 0 for 1 cycle -> all outputs zero, no ack, and the next request is served from ptr = 0.
